// File: rtl/seq_slice_adder_ctrl.sv
// Multi-cycle adder: one SLICE-bit ripple-carry slice reused NSLICE times, LSB slice first.
// The inter-slice carry is kept in a register, and the result is published only at RUN->DONE.
module seq_slice_adder_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 4,
  parameter int NSLICE = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("seq_slice_adder_ctrl: WIDTH must be a multiple of SLICE");
  end
  if (NSLICE < 2) begin : g_bad_nslice
    $error("seq_slice_adder_ctrl: NSLICE must be at least 2");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The producer holds in_valid and its operands until in_ready, and out_valid is held until out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg;
  logic [CW-1:0]     cnt;
  logic [SLICE:0]    slice_sum;
  logic              accept, last_slice;

  assign slice_sum  = {1'b0, a_reg[SLICE-1:0]} + {1'b0, b_reg[SLICE-1:0]}
                    + {{SLICE{1'b0}}, carry_reg};
  assign accept     = (state == IDLE) && in_valid;
  assign last_slice = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      cnt       <= '0;
    end else if (state == RUN) begin
      // Each finished slice enters at the top so the LSB slice ends up at bit 0.
      sum_reg   <= {slice_sum[SLICE-1:0], sum_reg[WIDTH-1:SLICE]};
      carry_reg <= slice_sum[SLICE];
      a_reg     <= a_reg >> SLICE;
      b_reg     <= b_reg >> SLICE;
      cnt       <= cnt + 1'b1;
    end
  end

  // Visible result only moves once per operation, on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_slice) begin
      sum  <= {slice_sum[SLICE-1:0], sum_reg[WIDTH-1:SLICE]};
      cout <= slice_sum[SLICE];
    end
  end

endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// Directed bench for seq_slice_adder_ctrl (WIDTH=32, SLICE=4): hand-computed sums,
// latency, backpressure, busy-time input, async reset mid-run and a short random run.
module tb_seq_slice_adder_ctrl;

  localparam int WIDTH  = 32;
  localparam int NSLICE = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_res;

  seq_slice_adder_ctrl #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; bp = cycles of out_ready=0 once DONE is reached.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tcin, input int bp, input bit rnd_ready);
    logic [WIDTH:0] exp;
    int lat;
    exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tcin});
    a = ta; b = tb_v; cin = tcin; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 2 * NSLICE) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("hold_during_run", {cout, sum}, last_res);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, NSLICE);
    exp = exp_q.pop_front();
    chk("result", {cout, sum}, exp);
    out_ready = 1'b0;
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", {cout, sum}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_idle", busy, 0);
    chk("hold_idle", {cout, sum}, exp);
    last_res = exp;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add and full carry ripple
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0);
    chk("basic_sum", sum, 32'hACF1_3569);
    chk("basic_cout", cout, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0);
    chk("ripple1", {cout, sum}, 33'h1_0000_0000);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    chk("ripple2", {cout, sum}, 33'h1_0000_0000);

    // Backpressure, then no duplicate result
    do_op(32'h0000_000F, 32'h0000_0001, 1'b0, 5, 1'b0);
    chk("bp_sum", {cout, sum}, 33'h0_0000_0010);
    @(posedge clk); #1;
    chk("no_dup", out_valid, 0);

    // Input held while busy
    a = 32'd1; b = 32'd1; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd5;
    repeat (NSLICE) @(posedge clk);
    #1;
    chk("busy_first_valid", out_valid, 1);
    chk("busy_first_sum", {cout, sum}, 33'd2);
    @(posedge clk); #1;
    chk("busy_back_idle", {busy, in_ready, out_valid}, 3'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_second_run", {busy, in_ready}, 2'b10);
    chk("busy_hold_first", {cout, sum}, 33'd2);
    repeat (NSLICE - 1) @(posedge clk);
    #1;
    chk("busy_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("busy_second_valid", out_valid, 1);
    chk("busy_second_sum", {cout, sum}, 33'hA);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("busy_second_done", out_valid, 0);
    last_res = 33'hA;

    // Async reset at counter==3
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_result", {cout, sum}, 0);
    repeat (NSLICE) begin
      @(posedge clk); #1;
      chk("rst_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    last_res = '0;
    @(posedge clk); #1;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    chk("post_rst", {cout, sum}, 33'h1_0000_0000);

    // Random regression with gaps and backpressure
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = ~ra;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
